// File: rtl/alu_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch_if
// Description : Request, ALU-side and result-side signals of alu_dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_dispatch_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_cmd;
  logic [WIDTH-1:0] in_op1;
  logic [WIDTH-1:0] in_op2;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [1:0]       alu_cmd;
  logic             alu_cin;
  logic             alu_req;
  logic             alu_ack;
  logic [15:0]      alu_result;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic             busy;

  modport master (
    input  in_valid, in_cmd, in_op1, in_op2, in_cin, in_tag,
    input  alu_ack, alu_result, res_ready,
    output in_ready, alu_op1, alu_op2, alu_cmd, alu_cin, alu_req,
    output res_valid, res_data, res_tag, res_err, busy
  );

  modport slave (
    output in_valid, in_cmd, in_op1, in_op2, in_cin, in_tag,
    output alu_ack, alu_result, res_ready,
    input  in_ready, alu_op1, alu_op2, alu_cmd, alu_cin, alu_req,
    input  res_valid, res_data, res_tag, res_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : alu_dispatch
// Description : FIFO-buffered issue stage driving the ALU Req/Ack handshake,
//               with a single-entry tagged result register and timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dispatch #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int GAP_CYC = 2
) (
  input wire             clk,
  input wire             rst_n,
  alu_dispatch_if.master bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * WIDTH + 3 + TAG_W;
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_REQ   = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ENTRY_W-1:0] fifo_mem_q [DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [1:0]         cmd_q, cmd_d;
  logic               cin_q, cin_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               res_valid_q, res_valid_d;
  logic [15:0]        res_data_q, res_data_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic               res_err_q, res_err_d;

  logic               fifo_empty, fifo_full, push, pop;
  logic [ENTRY_W-1:0] head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push       = bus.in_valid && !fifo_full;
  assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, push};

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    op1_d       = op1_q;
    op2_d       = op2_q;
    cmd_d       = cmd_q;
    cin_d       = cin_q;
    tag_d       = tag_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    res_valid_d = res_valid_q && !bus.res_ready;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    case (state_q)
      ST_IDLE: begin
        // A held result is never overwritten, so dispatch waits for it to drain.
        if (!fifo_empty && !res_valid_q) begin
          pop = 1'b1;
          {tag_d, cin_d, cmd_d, op2_d, op1_d} = head;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        to_cnt_d = '0;
        state_d  = ST_REQ;
      end
      ST_REQ: begin
        if (bus.alu_ack) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.alu_result;
          res_tag_d   = tag_q;
          res_err_d   = 1'b0;
          gap_cnt_d   = '0;
          state_d     = ST_GAP;
        end else if (to_cnt_q == TO_LAST) begin
          res_valid_d = 1'b1;
          res_data_d  = 16'h0000;
          res_tag_d   = tag_q;
          res_err_d   = 1'b1;
          gap_cnt_d   = '0;
          state_d     = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      cmd_q       <= '0;
      cin_q       <= 1'b0;
      tag_q       <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      cmd_q       <= cmd_d;
      cin_q       <= cin_d;
      tag_q       <= tag_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.in_tag, bus.in_cin, bus.in_cmd,
                                          bus.in_op2, bus.in_op1};
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.alu_op1   = op1_q;
  assign bus.alu_op2   = op2_q;
  assign bus.alu_cmd   = cmd_q;
  assign bus.alu_cin   = cin_q;
  assign bus.alu_req   = (state_q == ST_REQ);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_err   = res_err_q;
  assign bus.busy      = (state_q != ST_IDLE) || !fifo_empty;
endmodule
`default_nettype wire

// File: tb/tb_alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_dispatch
// Description : Directed scoreboard bench for alu_dispatch with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_dispatch;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int GAP_CYC = 2;
  localparam int ACK_DLY = 2;
  localparam int K_NORM  = 0;
  localparam int K_TO    = 1;
  localparam int K_NONE  = 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [15:0]      data;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic ack_en;
  logic stray_ack;
  int   last_hi_len = 0;

  alu_dispatch_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bif ();

  alu_dispatch #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W),
    .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [1:0] c, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
    case (c)
      2'b00:   return {8'h00, a} + {8'h00, b} + {15'h0000, ci};
      2'b01:   return {8'h00, a} - {8'h00, b} - {15'h0000, ci};
      2'b10:   return 16'(a) * 16'(b);
      default: return (b != 8'h00) ? {a % b, a / b} : 16'hFFFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic push(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [3:0] tag, input int kind);
    exp_t e;
    bif.in_valid = 1'b1;
    bif.in_cmd   = cmd;
    bif.in_op1   = a;
    bif.in_op2   = b;
    bif.in_cin   = ci;
    bif.in_tag   = tag;
    for (int i = 0; i < 300 && bif.in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("in_ready before push", bif.in_ready, 1);
    e.tag  = tag;
    e.data = (kind == K_TO) ? 16'h0000 : alu_fn(cmd, a, b, ci);
    e.err  = (kind == K_TO);
    if (kind != K_NONE) sb.push_back(e);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    bif.res_ready = v;
  endtask

  task automatic wait_res_valid();
    @(negedge clk);
    for (int i = 0; i < 300 && bif.res_valid !== 1'b1; i++) @(negedge clk);
    check("res_valid wait", bif.res_valid, 1);
  endtask

  task automatic wait_sb_empty();
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard drain", sb.size(), 0);
  endtask

  // ALU model: acks on the (ACK_DLY+1)-th Req-high cycle; echoes stray_ack when Req is low.
  initial begin
    int req_cnt;
    req_cnt        = 0;
    bif.alu_ack    = 1'b0;
    bif.alu_result = 16'hBEEF;
    forever begin
      @(negedge clk);
      if (bif.alu_req === 1'b1) begin
        req_cnt++;
        if (ack_en && req_cnt == ACK_DLY + 1) begin
          bif.alu_ack    = 1'b1;
          bif.alu_result = alu_fn(bif.alu_cmd, bif.alu_op1, bif.alu_op2, bif.alu_cin);
        end else begin
          bif.alu_ack    = 1'b0;
          bif.alu_result = 16'hBEEF;
        end
      end else begin
        req_cnt        = 0;
        bif.alu_ack    = stray_ack;
        bif.alu_result = 16'hBEEF;
      end
    end
  end

  // Result monitor and Req timing tracker.
  initial begin
    exp_t e;
    logic prev_req;
    logic seen_hi;
    int   hi_cnt;
    int   lo_cnt;
    prev_req = 1'b0;
    seen_hi  = 1'b0;
    hi_cnt   = 0;
    lo_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_req = 1'b0;
        seen_hi  = 1'b0;
        hi_cnt   = 0;
        lo_cnt   = 0;
      end else begin
        if (bif.alu_req === 1'b1) begin
          if (!prev_req) begin
            if (seen_hi) check("req low gap >= GAP_CYC", 32'(lo_cnt >= GAP_CYC), 1);
            hi_cnt = 0;
          end
          hi_cnt++;
          seen_hi = 1'b1;
        end else begin
          if (prev_req) begin
            last_hi_len = hi_cnt;
            lo_cnt      = 0;
          end
          lo_cnt++;
        end
        prev_req = (bif.alu_req === 1'b1);
        if (bif.res_valid === 1'b1 && bif.res_ready === 1'b1) begin
          if (sb.size() == 0) begin
            check("scoreboard underflow", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("res_data", bif.res_data, e.data);
            check("res_tag", bif.res_tag, e.tag);
            check("res_err", bif.res_err, e.err);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    ack_en        = 1'b1;
    stray_ack     = 1'b0;
    bif.in_valid  = 1'b0;
    bif.in_cmd    = 2'b00;
    bif.in_op1    = 8'h00;
    bif.in_op2    = 8'h00;
    bif.in_cin    = 1'b0;
    bif.in_tag    = 4'h0;
    bif.res_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset alu_req", bif.alu_req, 0);
    check("reset alu_op1", bif.alu_op1, 0);
    check("reset res_valid", bif.res_valid, 0);
    check("reset res_data", bif.res_data, 0);
    check("reset res_tag", bif.res_tag, 0);
    check("reset res_err", bif.res_err, 0);
    check("reset busy", bif.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", bif.in_ready, 1);

    // Single add: latency of Req and result capture
    set_ready(1'b0);
    push(2'b00, 8'h12, 8'h34, 1'b0, 4'd3, K_NORM);
    @(negedge clk); check("req low cycle 1", bif.alu_req, 0);
    @(negedge clk); check("req low cycle 2", bif.alu_req, 0);
    @(negedge clk); check("req high cycle 3", bif.alu_req, 1);
    check("alu_op1 driven", bif.alu_op1, 8'h12);
    check("alu_op2 driven", bif.alu_op2, 8'h34);
    @(negedge clk); check("res_valid cycle 4", bif.res_valid, 0);
    @(negedge clk); check("res_valid cycle 5", bif.res_valid, 0);
    @(negedge clk); check("res_valid cycle 6", bif.res_valid, 1);
    check("first res_data", bif.res_data, 16'h0046);
    check("first res_tag", bif.res_tag, 3);
    check("first res_err", bif.res_err, 0);
    set_ready(1'b1);
    wait_sb_empty();

    // Five back-to-back requests, in-order results
    @(posedge clk); #1;
    push(2'b00, 8'hFF, 8'h01, 1'b1, 4'd0, K_NORM);
    push(2'b01, 8'h10, 8'h20, 1'b0, 4'd1, K_NORM);
    push(2'b10, 8'h0F, 8'h11, 1'b0, 4'd2, K_NORM);
    push(2'b11, 8'h64, 8'h07, 1'b0, 4'd3, K_NORM);
    push(2'b01, 8'h80, 8'h01, 1'b1, 4'd4, K_NORM);
    wait_sb_empty();

    // Held result stalls dispatch; FIFO fills to DEPTH
    set_ready(1'b0);
    push(2'b00, 8'h01, 8'h01, 1'b1, 4'd5, K_NORM);
    wait_res_valid();
    @(posedge clk); #1;
    push(2'b00, 8'h21, 8'h02, 1'b0, 4'd6, K_NORM);
    push(2'b01, 8'h05, 8'h03, 1'b1, 4'd7, K_NORM);
    push(2'b10, 8'h12, 8'h10, 1'b0, 4'd8, K_NORM);
    push(2'b11, 8'hC8, 8'h0A, 1'b0, 4'd9, K_NORM);
    @(negedge clk);
    check("in_ready when full", bif.in_ready, 0);
    check("busy when stalled", bif.busy, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no dispatch while res_valid", bif.alu_req, 0);
    end
    set_ready(1'b1);
    wait_sb_empty();
    check("in_ready after drain", bif.in_ready, 1);

    // Timeout, then the next queued request issues normally
    @(posedge clk); #1;
    ack_en = 1'b0;
    push(2'b10, 8'h03, 8'h03, 1'b0, 4'd10, K_TO);
    push(2'b00, 8'h01, 8'h02, 1'b0, 4'd11, K_NORM);
    for (int i = 0; i < 300 && sb.size() > 1; i++) @(negedge clk);
    check("timeout result seen", sb.size(), 1);
    check("req high length on timeout", last_hi_len, TIMEOUT);
    ack_en = 1'b1;
    wait_sb_empty();

    // Reset while in REQ; later acks are ignored
    @(posedge clk); #1;
    ack_en = 1'b0;
    push(2'b00, 8'h44, 8'h55, 1'b0, 4'd12, K_NONE);
    @(negedge clk);
    for (int i = 0; i < 50 && bif.alu_req !== 1'b1; i++) @(negedge clk);
    check("req before reset", bif.alu_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset mid-req alu_req", bif.alu_req, 0);
    check("reset mid-req res_valid", bif.res_valid, 0);
    check("reset mid-req busy", bif.busy, 0);
    check("reset mid-req in_ready", bif.in_ready, 1);
    check("reset mid-req alu_op1", bif.alu_op1, 0);
    @(posedge clk); #1;
    stray_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ack after reset ignored", bif.res_valid, 0);
    end
    @(posedge clk); #1;
    stray_ack = 1'b0;
    ack_en    = 1'b1;

    // Stray acks during GAP and IDLE leave the result register alone
    set_ready(1'b0);
    push(2'b10, 8'h0C, 8'h0D, 1'b0, 4'd13, K_NORM);
    wait_res_valid();
    @(posedge clk); #1;
    stray_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stray ack res_valid", bif.res_valid, 1);
      check("stray ack res_data", bif.res_data, sb[0].data);
      check("stray ack res_tag", bif.res_tag, sb[0].tag);
    end
    @(posedge clk); #1;
    stray_ack = 1'b0;
    set_ready(1'b1);
    wait_sb_empty();
    @(posedge clk); #1;
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle stray ack res_valid", bif.res_valid, 0);
      check("idle stray ack busy", bif.busy, 0);
    end
    @(posedge clk); #1;
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
